// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Multi-cycle execute-stage controller on the driving side of an external
// combinational ALU. One request is accepted in IDLE. The unit then reads its
// operands from an internal register file, presents them to the ALU, captures
// the ALU result and flags, and writes them back. Each request takes four
// cycles: IDLE (handshake), READ, EXEC and WB.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op                ALU opcode (0..9 legal, 10..31 illegal)
//   req_src, req_dest     source index and destination/second-operand index
//   req_imm_en, req_imm   use the immediate in place of R[req_src]
//   alu_a, alu_b, alu_op  operands and opcode sent to the ALU (registered)
//   alu_out, alu_flags    combinational ALU response
//   done, err             one-cycle pulses in WB (err for an illegal opcode)
//   result                last captured ALU output, held until the next WB
//   flags                 processor flags register
//   dbg_addr, dbg_data    combinational register-file read port
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int OP_W   = 5,
  parameter int FLAG_W = 5,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [AW-1:0]     req_src,
  input  logic [AW-1:0]     req_dest,
  input  logic              req_imm_en,
  input  logic [DATA_W-1:0] req_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [OP_W-1:0] OP_CMP  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LAST = OP_W'(9);

  state_t              state;
  logic [DATA_W-1:0]   rf [NREGS];

  // Command registers, captured at the handshake and held for the whole op.
  logic [OP_W-1:0]     cmd_op;
  logic [AW-1:0]       cmd_src;
  logic [AW-1:0]       cmd_dest;
  logic                cmd_imm_en;
  logic [DATA_W-1:0]   cmd_imm;
  logic [FLAG_W-1:0]   flags_stage;

  logic                op_legal;
  assign op_legal = (cmd_op <= OP_LAST);

  assign dbg_data = rf[dbg_addr];

  // NOTE: every register here is written with <= so that all state reads the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      // NOTE: the register file must come up as all zeros, so it is cleared
      // explicitly; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      cmd_op      <= '0;
      cmd_src     <= '0;
      cmd_dest    <= '0;
      cmd_imm_en  <= 1'b0;
      cmd_imm     <= '0;
      flags_stage <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      result      <= '0;
      flags       <= '0;
      req_ready   <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // done/err are pulses: asserted only on the edge that enters WB.
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cmd_op     <= req_op;
            cmd_src    <= req_src;
            cmd_dest   <= req_dest;
            cmd_imm_en <= req_imm_en;
            cmd_imm    <= req_imm;
            req_ready  <= 1'b0;
            state      <= READ;
          end
        end
        READ: begin
          alu_a  <= cmd_imm_en ? cmd_imm : rf[cmd_src];
          alu_b  <= rf[cmd_dest];
          alu_op <= cmd_op;
          state  <= EXEC;
        end
        EXEC: begin
          result      <= alu_out;
          flags_stage <= alu_flags;
          done        <= 1'b1;
          err         <= !op_legal;
          state       <= WB;
        end
        WB: begin
          // Illegal opcodes leave both the register file and flags untouched;
          // CMP only updates flags.
          if (op_legal) begin
            flags <= flags_stage;
            if (cmd_op != OP_CMP) rf[cmd_dest] <= result;
          end
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Bench for alu_exec_unit. It plays the external ALU with a simple function,
// keeps a transaction-level model of the register file, flags and result,
// and compares the DUT against that model on every falling edge. Directed
// sequences add literal expectations that pin the model itself.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [3:0]  req_src = '0;
  logic [3:0]  req_dest = '0;
  logic        req_imm_en = 1'b0;
  logic [15:0] req_imm = '0;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [15:0] alu_out;
  logic [4:0]  alu_flags;
  logic        done, err;
  logic [15:0] result;
  logic [4:0]  flags;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src(req_src), .req_dest(req_dest),
    .req_imm_en(req_imm_en), .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .done(done), .err(err), .result(result), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External ALU: a = Rsrc, b = Rdest. Flags = {zero, neg, a>b, op[1:0]}.
  function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [4:0] op);
    logic [15:0] o;
    case (op)
      5'd0:    o = b + a;
      5'd1:    o = b - a;
      5'd2:    o = b - a;
      5'd3:    o = a & b;
      5'd4:    o = a | b;
      5'd5:    o = a ^ b;
      5'd6:    o = ~a;
      5'd7:    o = a << 1;
      5'd8:    o = a >> 1;
      5'd9:    o = {a[15], a[15:1]};
      default: o = 16'hDEAD;
    endcase
    return {o == 16'h0, o[15], a > b, op[1:0], o};
  endfunction

  assign {alu_flags, alu_out} = alu_fn(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // Phase counts cycles within one operation: 0 = waiting for a request,
  // 1..3 = the three busy cycles; done is due in the last of them.
  logic [15:0] m_regs [16];
  logic [15:0] m_a, m_b, m_result;
  logic [4:0]  m_op, m_flags, m_stage;
  logic [4:0]  c_op;
  logic [3:0]  c_src, c_dest;
  logic        c_imm_en;
  logic [15:0] c_imm;
  int          m_phase = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_a = '0; m_b = '0; m_op = '0; m_result = '0; m_flags = '0; m_stage = '0;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
             c_op = req_op; c_src = req_src; c_dest = req_dest;
             c_imm_en = req_imm_en; c_imm = req_imm;
             m_phase = 1;
           end
        1: begin
             m_a = c_imm_en ? c_imm : m_regs[c_src];
             m_b = m_regs[c_dest];
             m_op = c_op;
             m_phase = 2;
           end
        2: begin
             {m_stage, m_result} = alu_fn(m_a, m_b, m_op);
             m_phase = 3;
           end
        default: begin
             if (c_op <= 5'd9) begin
               m_flags = m_stage;
               if (c_op != 5'd2) m_regs[c_dest] = m_result;
             end
             m_phase = 0;
           end
      endcase
    end
  end

  // Compare process: every falling edge once the model has been reset.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",    {31'b0, req_ready}, {31'b0, m_phase == 0});
      check("done",     {31'b0, done},      {31'b0, m_phase == 3});
      check("err",      {31'b0, err},       {31'b0, m_phase == 3 && c_op > 5'd9});
      check("alu_a",    {16'b0, alu_a},     {16'b0, m_a});
      check("alu_b",    {16'b0, alu_b},     {16'b0, m_b});
      check("alu_op",   {27'b0, alu_op},    {27'b0, m_op});
      check("result",   {16'b0, result},    {16'b0, m_result});
      check("flags",    {27'b0, flags},     {27'b0, m_flags});
      check("dbg_data", {16'b0, dbg_data},  {16'b0, m_regs[dbg_addr]});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issues one request and returns at the falling edge after WB (back in IDLE).
  task automatic do_op(input logic [4:0] op, input logic [3:0] src, input logic [3:0] dest,
                       input logic imm_en, input logic [15:0] imm);
    @(negedge clk);
    wait_ready();
    req_op = op; req_src = src; req_dest = dest; req_imm_en = imm_en; req_imm = imm;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reg(input logic [3:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check($sformatf("R%0d", addr), {16'b0, dbg_data}, {16'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1. Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 16; i++) check_reg(4'(i), 16'h0);
    check("rst_flags", {27'b0, flags}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_done",  {31'b0, done}, 32'd0);

    // 2. Immediate loads via OR, then ADD
    do_op(5'd4, 4'd0, 4'd1, 1'b1, 16'h1234);
    check_reg(4'd1, 16'h1234);
    do_op(5'd4, 4'd0, 4'd2, 1'b1, 16'hAF0C);
    check_reg(4'd2, 16'hAF0C);
    do_op(5'd0, 4'd2, 4'd1, 1'b0, 16'h0);
    check_reg(4'd1, 16'hC140);
    check("add_flags", {27'b0, flags}, {27'b0, 5'b01100});

    // 3. CMP: flags only
    do_op(5'd2, 4'd1, 4'd2, 1'b0, 16'h0);
    check_reg(4'd1, 16'hC140);
    check_reg(4'd2, 16'hAF0C);
    check("cmp_result", {16'b0, result}, {16'b0, 16'hEDCC});
    check("cmp_flags",  {27'b0, flags}, {27'b0, 5'b01110});

    // 4. Shifts and NOT on R3 = 0x8001
    do_op(5'd4, 4'd0, 4'd3, 1'b1, 16'h8001);
    do_op(5'd9, 4'd3, 4'd4, 1'b0, 16'h0);
    check_reg(4'd4, 16'hC000);
    do_op(5'd8, 4'd3, 4'd5, 1'b0, 16'h0);
    check_reg(4'd5, 16'h4000);
    do_op(5'd6, 4'd3, 4'd6, 1'b0, 16'h0);
    check_reg(4'd6, 16'h7FFE);
    check_reg(4'd3, 16'h8001);
    check("not_flags", {27'b0, flags}, {27'b0, 5'b00110});

    // 5. Illegal opcode: err/done pulse, nothing written
    do_op(5'd31, 4'd0, 4'd1, 1'b0, 16'h0);
    check_reg(4'd1, 16'hC140);
    check("ill_flags",  {27'b0, flags}, {27'b0, 5'b00110});
    check("ill_result", {16'b0, result}, {16'b0, 16'hDEAD});

    // 6. Reset during EXEC of XOR into R7; a request while busy is ignored
    do_op(5'd4, 4'd0, 4'd7, 1'b1, 16'h00FF);
    check_reg(4'd7, 16'h00FF);
    @(negedge clk);
    req_op = 5'd5; req_src = 4'd3; req_dest = 4'd7; req_imm_en = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);                       // READ: present an unrelated request
    req_op = 5'd4; req_dest = 4'd9; req_imm_en = 1'b1; req_imm = 16'h5555;
    @(negedge clk);                       // EXEC: drop valid, assert reset
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 16; i++) check_reg(4'(i), 16'h0);
    check("abort_flags", {27'b0, flags}, 32'd0);
    repeat (3) @(negedge clk);            // no late done pulse (compare process)

    // After the abort the unit accepts work again
    do_op(5'd0, 4'd0, 4'd0, 1'b1, 16'h0005);
    check_reg(4'd0, 16'h0005);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
